// File: rtl/if_id_regs_if.sv
// Signal bundle between the fetch/decode stages and the IF/ID boundary registers.
// The master side is the surrounding pipeline; the slave side is if_id_regs.
interface if_id_regs_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      npc;
    logic [31:0]      pc4;
    logic [31:0]      inst;
    logic [1:0]       pcsource;
    logic             wpcir;
    logic [31:0]      pc;
    logic [31:0]      dpc4;
    logic [31:0]      dinst;
    logic             dvalid;
    logic [CNT_W-1:0] inst_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output npc, pc4, inst, pcsource, wpcir,
        input  pc, dpc4, dinst, dvalid, inst_cnt, stall_cnt, flush_cnt
    );

    modport slave (
        input  npc, pc4, inst, pcsource, wpcir,
        output pc, dpc4, dinst, dvalid, inst_cnt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/if_id_regs.sv
// PC register and IF/ID pipeline register with load-use stall, optional
// wrong-path squash on redirect, and saturating performance counters.
module if_id_regs #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          DELAY_SLOT = 1'b1,
    parameter int          CNT_W      = 32
) (
    input  logic         clock,
    input  logic         reset,
    if_id_regs_if.slave  bus
);
    logic [31:0]      pc_q;
    logic [31:0]      dpc4_q;
    logic [31:0]      dinst_q;
    logic             dvalid_q;
    logic [CNT_W-1:0] inst_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             squash;

    // With delay slots the fetched instruction after a redirect is architecturally live.
    assign squash = (bus.pcsource != 2'b00) && !DELAY_SLOT;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            dpc4_q      <= 32'h0;
            dinst_q     <= 32'h0;
            dvalid_q    <= 1'b0;
            inst_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!bus.wpcir) begin
            // The redirect decision is invalid while stalled, so pcsource is ignored here.
            if (stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end else if (squash) begin
            pc_q     <= bus.npc;
            dpc4_q   <= bus.pc4;
            dinst_q  <= 32'h0;
            dvalid_q <= 1'b0;
            if (flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end else begin
            pc_q     <= bus.npc;
            dpc4_q   <= bus.pc4;
            dinst_q  <= bus.inst;
            dvalid_q <= 1'b1;
            if (inst_cnt_q != '1)
                inst_cnt_q <= inst_cnt_q + 1'b1;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.dpc4      = dpc4_q;
    assign bus.dinst     = dinst_q;
    assign bus.dvalid    = dvalid_q;
    assign bus.inst_cnt  = inst_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
endmodule
